// File: rtl/key_expansion_ctrl_if.sv
// Handshake/data bundle between the key-schedule sequencer and its user.
// The master drives start/key/read index; the slave returns stream, status and store data.
interface key_expansion_ctrl_if;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         keys_ready;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output start, key_in, rd_idx,
        input  busy, done, rk_valid, rk_round, rk_out, keys_ready, rd_key
    );

    modport slave (
        input  start, key_in, rd_idx,
        output busy, done, rk_valid, rk_round, rk_out, keys_ready, rd_key
    );
endinterface

// File: rtl/key_expansion_ctrl.sv
// Iterative AES-128 key schedule: one round key per clock, streamed and stored; round 0 one cycle after start.
// No backpressure: the stream cannot stall, and start is ignored unless the sequencer is idle.
module key_expansion_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic               clk,
    input  logic               rst,
    key_expansion_ctrl_if.slave bus
);
    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [KEY_W-1:0]   work;
    logic [KEY_W-1:0]   work_nxt;
    logic               keys_ready;
    logic [KEY_W-1:0]   store [0:NR];

    // Byte 0x00 sits in the MSBs of the table, so its LSB offset is 8*(255-x).
    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // The counter holds the index of the key in work, which is also the Rcon index for the next one.
    always_comb begin
        logic [31:0] w0, w1, w2, w3, rot, t;
        w0  = work[127:96];
        w1  = work[95:64];
        w2  = work[63:32];
        w3  = work[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {sub_byte(rot[31:24]), sub_byte(rot[23:16]),
               sub_byte(rot[15:8]),  sub_byte(rot[7:0])} ^ {rcon(cnt), 24'h000000};
        w0  = w0 ^ t;
        w1  = w1 ^ w0;
        w2  = w2 ^ w1;
        w3  = w3 ^ w2;
        work_nxt = {w0, w1, w2, w3};
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = LOAD;
            LOAD:    state_nxt = EXPAND;
            EXPAND:  if (cnt == LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state != IDLE);
        bus.rk_valid   = (state != IDLE);
        bus.rk_round   = (state != IDLE) ? cnt : 4'd0;
        bus.rk_out     = (state != IDLE) ? work : '0;
        bus.done       = (state == EXPAND) && (cnt == LAST);
        bus.keys_ready = keys_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 4'd0;
            work       <= '0;
            keys_ready <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                work       <= bus.key_in;
                cnt        <= 4'd0;
                keys_ready <= 1'b0;
            end
        end else if (cnt == LAST) begin
            cnt        <= 4'd0;
            keys_ready <= 1'b1;
        end else begin
            work <= work_nxt;
            cnt  <= cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state != IDLE) store[cnt] <= work;
    end

    assign bus.rd_key = (bus.rd_idx > LAST) ? '0 : store[bus.rd_idx];
endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl: FIPS-197 schedule, store reads, ignored restart,
// mid-run reset, zero key and back-to-back runs with start held high.
module tb_key_expansion_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    key_expansion_ctrl_if bus ();

    key_expansion_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] fips_rk [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one schedule and follow it cycle by cycle; c is the cycle offset from the start edge.
    task automatic run_sched(input logic [127:0] key, input logic [127:0] r1, input logic [127:0] r10,
                             input int pulse_at, input int rst_at);
        bus.key_in = key;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == rst_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("rst_busy",  {127'd0, bus.busy},       128'd0);
                check("rst_valid", {127'd0, bus.rk_valid},   128'd0);
                check("rst_ready", {127'd0, bus.keys_ready}, 128'd0);
                check("rst_round", {124'd0, bus.rk_round},   128'd0);
                return;
            end
            check($sformatf("valid_c%0d", c), {127'd0, bus.rk_valid}, 128'd1);
            check($sformatf("busy_c%0d", c),  {127'd0, bus.busy},     128'd1);
            check($sformatf("round_c%0d", c), {124'd0, bus.rk_round}, 128'(c - 1));
            check($sformatf("done_c%0d", c),  {127'd0, bus.done},     128'(c == 11));
            if (c == 1) begin
                check("rk0", bus.rk_out, key);
                check("ready_clr", {127'd0, bus.keys_ready}, 128'd0);
            end
            if (c == 2)  check("rk1", bus.rk_out, r1);
            if (c == 11) check("rk10", bus.rk_out, r10);
            bus.start  = (c == pulse_at);
            if (c == pulse_at) bus.key_in = ~key;
            tick();
        end
        bus.start = 1'b0;
        check("end_busy",  {127'd0, bus.busy},       128'd0);
        check("end_valid", {127'd0, bus.rk_valid},   128'd0);
        check("end_done",  {127'd0, bus.done},       128'd0);
        check("end_ready", {127'd0, bus.keys_ready}, 128'd1);
        check("end_rkout", bus.rk_out,               128'd0);
    endtask

    initial begin
        int dones;
        int vcount;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.key_in = '0;
        bus.rd_idx = 4'd0;
        tick();
        tick();
        check("por_busy",  {127'd0, bus.busy},       128'd0);
        check("por_done",  {127'd0, bus.done},       128'd0);
        check("por_valid", {127'd0, bus.rk_valid},   128'd0);
        check("por_round", {124'd0, bus.rk_round},   128'd0);
        check("por_rkout", bus.rk_out,               128'd0);
        check("por_ready", {127'd0, bus.keys_ready}, 128'd0);
        rst = 1'b0;
        tick();

        run_sched(FIPS_KEY, fips_rk[1], fips_rk[10], 0, 0);

        for (int i = 0; i <= 10; i++) begin
            bus.rd_idx = 4'(i);
            #1;
            check($sformatf("store_%0d", i), bus.rd_key, fips_rk[i]);
        end
        bus.rd_idx = 4'd11;
        #1;
        check("store_11", bus.rd_key, 128'd0);
        bus.rd_idx = 4'd15;
        #1;
        check("store_15", bus.rd_key, 128'd0);
        tick();

        run_sched(FIPS_KEY, fips_rk[1], fips_rk[10], 5, 0);
        bus.rd_idx = 4'd5;
        #1;
        check("restart_store5", bus.rd_key, fips_rk[5]);
        tick();

        run_sched(FIPS_KEY, fips_rk[1], fips_rk[10], 0, 6);
        tick();
        check("post_rst_ready", {127'd0, bus.keys_ready}, 128'd0);
        run_sched(128'd0, 128'h62636363626363636263636362636363,
                  128'hb4ef5bcb3e92e21123e951cf6f8f188e, 0, 0);
        tick();

        dones      = 0;
        vcount     = 0;
        bus.key_in = FIPS_KEY;
        bus.start  = 1'b1;
        tick();
        for (int c = 1; c <= 36; c++) begin
            check($sformatf("b2b_valid_c%0d", c), {127'd0, bus.rk_valid}, 128'((c % 12) != 0));
            check($sformatf("b2b_busy_c%0d", c),  {127'd0, bus.busy},     128'((c % 12) != 0));
            check($sformatf("b2b_done_c%0d", c),  {127'd0, bus.done},     128'((c % 12) == 11));
            if ((c % 12) != 0)
                check($sformatf("b2b_round_c%0d", c), {124'd0, bus.rk_round}, 128'((c - 1) % 12));
            if ((c % 12) == 1)
                check($sformatf("b2b_rk0_c%0d", c), bus.rk_out, FIPS_KEY);
            if (bus.done) dones++;
            if (bus.rk_valid) vcount++;
            if (c == 36) bus.start = 1'b0;
            tick();
        end
        check("b2b_dones",   128'(dones),  128'd3);
        check("b2b_vcount",  128'(vcount), 128'd33);
        check("b2b_stopped", {127'd0, bus.busy}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
